// File: rtl/stg_hazard_ctl.sv
// stg_hazard_ctl: decode-stage hazard controller.
// Tracks GP/SR registers with writes in flight, stalls decode on RAW/WAW
// hazards, and holds a multi-cycle flush after a branch redirect.
// Optional statistics counters are built when STG_HAZARD_STATS_EN is defined.
module stg_hazard_ctl #(
   parameter int GP_AW        = 4,
   parameter int SR_AW        = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  iw_clk,
   input  logic                  iw_rst,
   input  logic                  iw_id_valid,
   input  logic                  iw_has_src_gp,
   input  logic [GP_AW-1:0]      iw_src_gp,
   input  logic [GP_AW-1:0]      iw_tgt_gp,
   input  logic                  iw_has_tgt_gp,
   input  logic                  iw_tgt_gp_we,
   input  logic                  iw_has_src_sr,
   input  logic [SR_AW-1:0]      iw_src_sr,
   input  logic [SR_AW-1:0]      iw_tgt_sr,
   input  logic                  iw_has_tgt_sr,
   input  logic                  iw_tgt_sr_we,
   input  logic                  iw_wb_gp_we,
   input  logic [GP_AW-1:0]      iw_wb_gp_addr,
   input  logic                  iw_wb_sr_we,
   input  logic [SR_AW-1:0]      iw_wb_sr_addr,
   input  logic                  iw_redirect,
   input  logic                  iw_stats_clr,
   output logic                  ow_stall,
   output logic                  ow_flush,
   output logic                  ow_issue,
   output logic [2**GP_AW-1:0]   ow_gp_pending,
   output logic [2**SR_AW-1:0]   ow_sr_pending,
   output logic [31:0]           ow_stall_cnt,
   output logic [31:0]           ow_flush_cnt
);

   localparam int GP_N  = 2**GP_AW;
   localparam int SR_N  = 2**SR_AW;
   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam bit HAS_FLUSH_ST = (FLUSH_CYCLES > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [GP_N-1:0]   gp_pend_q, gp_pend_d, wb_gp_mask, eff_gp;
   logic [SR_N-1:0]   sr_pend_q, sr_pend_d, wb_sr_mask, eff_sr;
   logic              hazard, flush, issue;

   // Effective pending (writeback this cycle resolves the hazard) and hazard detect
   always_comb begin
      wb_gp_mask = '0;
      wb_sr_mask = '0;
      if (iw_wb_gp_we) wb_gp_mask[iw_wb_gp_addr] = 1'b1;
      if (iw_wb_sr_we) wb_sr_mask[iw_wb_sr_addr] = 1'b1;
      eff_gp = gp_pend_q & ~wb_gp_mask;
      eff_sr = sr_pend_q & ~wb_sr_mask;
      hazard = ~iw_rst & iw_id_valid & (
                 (iw_has_src_gp & eff_gp[iw_src_gp]) |
                 ((iw_has_tgt_gp | iw_tgt_gp_we) & eff_gp[iw_tgt_gp]) |
                 (iw_has_src_sr & eff_sr[iw_src_sr]) |
                 ((iw_has_tgt_sr | iw_tgt_sr_we) & eff_sr[iw_tgt_sr]));
      flush  = ~iw_rst & (iw_redirect | (state_q == ST_FLUSH));
      issue  = ~iw_rst & iw_id_valid & ~hazard & ~flush;
   end

   assign ow_stall      = hazard & ~flush;
   assign ow_flush      = flush;
   assign ow_issue      = issue;
   assign ow_gp_pending = gp_pend_q;
   assign ow_sr_pending = sr_pend_q;

   // Scoreboard next state: writeback clears, issuing producer sets (set wins)
   always_comb begin
      gp_pend_d = gp_pend_q & ~wb_gp_mask;
      sr_pend_d = sr_pend_q & ~wb_sr_mask;
      if (issue & iw_tgt_gp_we) gp_pend_d[iw_tgt_gp] = 1'b1;
      if (issue & iw_tgt_sr_we) sr_pend_d[iw_tgt_sr] = 1'b1;
   end

   // Flush FSM next state: the redirect cycle itself flushes, FLUSH covers the rest
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (iw_redirect && HAS_FLUSH_ST) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_FLUSH: begin
            if (iw_redirect) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         gp_pend_q <= '0;
         sr_pend_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gp_pend_q <= gp_pend_d;
         sr_pend_q <= sr_pend_d;
      end
   end

`ifdef STG_HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   // Statistics next state: clear beats increment, counters wrap naturally
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (iw_stats_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (ow_stall)    stall_cnt_d = stall_cnt_q + 32'd1;
         if (iw_redirect) flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ow_stall_cnt = stall_cnt_q;
   assign ow_flush_cnt = flush_cnt_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = iw_stats_clr;
   assign ow_stall_cnt     = '0;
   assign ow_flush_cnt     = '0;
`endif

endmodule

// File: doc/stg_hazard_ctl.md
Name: stg_hazard_ctl

Overview:
Pipeline hazard controller that sequences the decode stage.
- Keeps a scoreboard of GP and SR registers with writes in flight.
- Drives the stall to the decode latch when a decoded source or target register is still pending.
- Generates a multi-cycle flush after a branch redirect.
- Sits between the decode stage outputs, execute-stage redirect and writeback.

Parameters:
GP_AW, 4, GP register address width (2**GP_AW scoreboard entries)
SR_AW, 2, SR register address width (2**SR_AW entries)
FLUSH_CYCLES, 2, cycles ow_flush stays high per redirect (>=1)

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset, asynchronous, active-high
iw_id_valid  in  1  decode output holds a real instruction
iw_has_src_gp  in  1  instruction reads iw_src_gp
iw_src_gp  in  GP_AW  GP source address
iw_tgt_gp  in  GP_AW  GP target address (read and/or written)
iw_has_tgt_gp  in  1  instruction reads iw_tgt_gp (CMP/ST/ALU dest)
iw_tgt_gp_we  in  1  instruction writes iw_tgt_gp
iw_has_src_sr  in  1  instruction reads iw_src_sr
iw_src_sr  in  SR_AW  SR source address
iw_tgt_sr  in  SR_AW  SR target address
iw_has_tgt_sr  in  1  instruction reads iw_tgt_sr
iw_tgt_sr_we  in  1  instruction writes iw_tgt_sr
iw_wb_gp_we  in  1  GP writeback this cycle
iw_wb_gp_addr  in  GP_AW  GP writeback address
iw_wb_sr_we  in  1  SR writeback this cycle
iw_wb_sr_addr  in  SR_AW  SR writeback address
iw_redirect  in  1  execute resolved a taken branch this cycle
iw_stats_clr  in  1  clear statistics counters
ow_stall  out  1  hold decode latch
ow_flush  out  1  flush fetch/decode latches
ow_issue  out  1  instruction leaves decode this cycle
ow_gp_pending  out  2**GP_AW  GP scoreboard bits
ow_sr_pending  out  2**SR_AW  SR scoreboard bits
ow_stall_cnt  out  32  stall-cycle count
ow_flush_cnt  out  32  redirect-event count

Behaviour:
Reset (async):
- All pending bits 0, FSM in RUN, counter 0, statistics 0.
- As a consequence, ow_stall=0, ow_flush=0 and ow_issue=0 while reset is asserted.

Effective pending:
- eff_gp[i] = gp_pending[i] & ~(iw_wb_gp_we & iw_wb_gp_addr==i). The register file writes through, so writeback in the same cycle resolves the hazard.
- eff_sr is formed the same way from the SR scoreboard and SR writeback.

Hazard (combinational):
- A hazard exists if iw_id_valid and any of the following holds:
  - has_src_gp & eff_gp[src_gp]
  - (has_tgt_gp | tgt_gp_we) & eff_gp[tgt_gp] (RAW and WAW)
  - the equivalent SR terms

Stall, flush and issue:
- ow_stall = hazard & ~ow_flush.
- ow_flush = iw_redirect | (state==FLUSH).
- ow_issue = iw_id_valid & ~hazard & ~ow_flush.

Scoreboard update (clocked):
- Writeback clears the bit at iw_wb_gp_addr / iw_wb_sr_addr.
- Issue with tgt_gp_we sets bit tgt_gp; issue with tgt_sr_we sets bit tgt_sr.
- Set and clear on the same index in one cycle: set wins, because the new producer is outstanding.
- Writeback to a non-pending index: no effect.

Flush FSM:
- RUN: on iw_redirect, go to FLUSH with cnt=FLUSH_CYCLES-1, provided FLUSH_CYCLES>1; otherwise stay in RUN.
- FLUSH: cnt decrements each cycle; exit to RUN when cnt==1 at the clock edge.
- iw_redirect while in FLUSH reloads cnt to FLUSH_CYCLES-1.
- Total ow_flush high time = FLUSH_CYCLES consecutive cycles from the last redirect.
- Flush never clears scoreboard bits. Only issued instructions set bits, and those instructions complete.

Latency:
- Stall and flush are combinational, zero cycles.
- The scoreboard is visible to the next instruction one cycle after issue.

Boundary rules:
- Redirect coincident with a hazard: flush dominates and ow_stall=0.
- iw_id_valid=0: no stall, no issue.
- Reset mid-FLUSH: returns to RUN immediately and drops all pending bits.

Optional Feature:
Macro STG_HAZARD_STATS_EN.
- Defined:
  - ow_stall_cnt increments on every cycle with ow_stall=1.
  - ow_flush_cnt increments on every cycle with iw_redirect=1.
  - Both wrap modulo 2**32.
  - iw_stats_clr zeroes both counters synchronously and takes priority over increment.
- Undefined: no counter flops; ow_stall_cnt and ow_flush_cnt are tied to 0 and iw_stats_clr is ignored.

Test Plan:
1. RAW stall: issue ADD with tgt_gp=3 and we=1. Next cycle, src_gp=3 valid -> ow_stall=1 and ow_issue=0. Stall persists until the cycle with wb_gp_we=1, addr=3; that cycle ow_stall=0 and ow_issue=1.
2. WAW stall: tgt_gp=5 pending, new instruction with tgt_gp=5 and we=1 -> stall. Writeback of 5 -> issue, and gp_pending[5] stays 1 due to the set-wins rule.
3. Redirect with FLUSH_CYCLES=2: iw_redirect pulse at cycle N -> ow_flush=1 at N and N+1, 0 at N+2. A second pulse at N+1 extends ow_flush through N+2.
4. Flush over hazard: src_gp pending plus iw_redirect -> ow_stall=0, ow_flush=1, ow_issue=0, and the pending bit is unchanged.
5. SR path: issue with tgt_sr_we=1, tgt_sr=2, then src_sr=2 -> stall. Writeback of SR 2 in the same cycle as the check -> no stall.
6. STG_HAZARD_STATS_EN: 7 stall cycles and 2 redirects -> ow_stall_cnt=7, ow_flush_cnt=2. iw_stats_clr -> both 0 next cycle. Async reset mid-FLUSH -> ow_flush=0 and all pending bits 0.
